// File: rtl/key_debounce_4ch.sv
// Four-channel key conditioner: 2-flop synchroniser, per-channel debounce FSM with
// stability counter, clean level output plus one-cycle press/release pulses.
module key_debounce_4ch #(
   parameter int P_DEBOUNCE = 1_000_000,
   parameter int P_CNT_W    = 20,
   parameter int P_KEY_POL  = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_key,
   output logic [3:0] o_key,
   output logic [3:0] o_press,
   output logic [3:0] o_release
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_PRESS_CHK = 2'd1;
   localparam logic [1:0] S_HOLD      = 2'd2;
   localparam logic [1:0] S_REL_CHK   = 2'd3;

   localparam logic [P_CNT_W-1:0] CNT_LAST = P_CNT_W'(P_DEBOUNCE - 1);

   logic [3:0] key_norm;
   logic [3:0] s1_q;
   logic [3:0] s2_q;

   // After normalisation a 1 always means pressed, so reset-to-0 never looks like a press.
   assign key_norm = (P_KEY_POL != 0) ? i_key : ~i_key;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= key_norm;
         s2_q <= s1_q;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ch
         logic [1:0]         state_q, state_d;
         logic [P_CNT_W-1:0] cnt_q, cnt_d;
         logic               key_q, key_d;
         logic               press_q, press_d;
         logic               rel_q, rel_d;

         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            key_d   = key_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            case (state_q)
               S_IDLE: begin
                  if (s2_q[gi]) begin
                     state_d = S_PRESS_CHK;
                     cnt_d   = '0;
                  end
               end
               S_PRESS_CHK: begin
                  if (!s2_q[gi]) begin
                     state_d = S_IDLE;
                     cnt_d   = '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_d = S_HOLD;
                     key_d   = 1'b1;
                     press_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               S_HOLD: begin
                  if (!s2_q[gi]) begin
                     state_d = S_REL_CHK;
                     cnt_d   = '0;
                  end
               end
               S_REL_CHK: begin
                  if (s2_q[gi]) begin
                     state_d = S_HOLD;
                     cnt_d   = '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_d = S_IDLE;
                     key_d   = 1'b0;
                     rel_d   = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            endcase
         end

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               key_q   <= 1'b0;
               press_q <= 1'b0;
               rel_q   <= 1'b0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
               key_q   <= key_d;
               press_q <= press_d;
               rel_q   <= rel_d;
            end
         end

         assign o_key[gi]     = key_q;
         assign o_press[gi]   = press_q;
         assign o_release[gi] = rel_q;
      end
   endgenerate

endmodule

// File: tb/tb_key_debounce_4ch.sv
// Directed bench for key_debounce_4ch: one active-high and one active-low instance,
// both with a debounce window of 4 cycles (output latency 6 edges after first sample).
module tb_key_debounce_4ch;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key_h = 4'h0;
   logic [3:0] key_l = 4'hF;
   logic [3:0] okey_h, opress_h, orel_h;
   logic [3:0] okey_l, opress_l, orel_l;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   key_debounce_4ch #(.P_DEBOUNCE(4), .P_CNT_W(3), .P_KEY_POL(1)) dut_h (
      .i_clk(clk), .i_rst(rst), .i_key(key_h),
      .o_key(okey_h), .o_press(opress_h), .o_release(orel_h)
   );

   key_debounce_4ch #(.P_DEBOUNCE(4), .P_CNT_W(3), .P_KEY_POL(0)) dut_l (
      .i_clk(clk), .i_rst(rst), .i_key(key_l),
      .o_key(okey_l), .o_press(opress_l), .o_release(orel_l)
   );

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int   cnt_p;
      int   cnt_r;
      logic sticky;
      logic steady;

      // Reset state
      step(2);
      chk("rst_h", {okey_h, opress_h, orel_h}, 32'h0);
      chk("rst_l", {okey_l, opress_l, orel_l}, 32'h0);
      rst = 1'b0;
      step(2);

      // Clean press/release on channel 0
      key_h[0] = 1'b1;
      step(6);
      chk("p0_before", {okey_h, opress_h}, 32'h00);
      step(1);
      $display("press ch0: o_key=%b o_press=%b", okey_h, opress_h);
      chk("p0_edge", {okey_h, opress_h}, 32'h11);
      step(1);
      chk("p0_after", {okey_h, opress_h}, 32'h10);
      step(12);
      key_h[0] = 1'b0;
      step(6);
      chk("r0_before", {okey_h, orel_h}, 32'h10);
      step(1);
      $display("release ch0: o_key=%b o_release=%b", okey_h, orel_h);
      chk("r0_edge", {okey_h, orel_h}, 32'h01);
      step(1);
      chk("r0_after", {okey_h, orel_h}, 32'h00);

      // Bounce rejection on channel 1
      sticky = 1'b0;
      key_h[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin step(1); sticky |= okey_h[1] | opress_h[1] | orel_h[1]; end
      key_h[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin step(1); sticky |= okey_h[1] | opress_h[1] | orel_h[1]; end
      key_h[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin step(1); sticky |= okey_h[1] | opress_h[1] | orel_h[1]; end
      key_h[1] = 1'b0;
      for (int i = 0; i < 12; i++) begin step(1); sticky |= okey_h[1] | opress_h[1] | orel_h[1]; end
      $display("bounce ch1: any activity=%b", sticky);
      chk("bounce_ch1", 32'(sticky), 32'h0);

      // Bouncy press that finally settles on channel 2
      cnt_p = 0;
      key_h[2] = 1'b1; step(1); cnt_p += int'(opress_h[2]);
      key_h[2] = 1'b0; for (int i = 0; i < 2; i++) begin step(1); cnt_p += int'(opress_h[2]); end
      key_h[2] = 1'b1; for (int i = 0; i < 2; i++) begin step(1); cnt_p += int'(opress_h[2]); end
      key_h[2] = 1'b0; step(1); cnt_p += int'(opress_h[2]);
      key_h[2] = 1'b1; for (int i = 0; i < 3; i++) begin step(1); cnt_p += int'(opress_h[2]); end
      key_h[2] = 1'b0; step(1); cnt_p += int'(opress_h[2]);
      key_h[2] = 1'b1;
      for (int i = 0; i < 6; i++) begin step(1); cnt_p += int'(opress_h[2]); end
      chk("settle_early", {cnt_p[3:0], okey_h[2]}, 32'h0);
      step(1);
      chk("settle_edge", {okey_h[2], opress_h[2]}, 32'h3);
      for (int i = 0; i < 20; i++) begin step(1); cnt_p += int'(opress_h[2]); end
      $display("settle ch2: extra presses=%0d", cnt_p);
      chk("settle_single", cnt_p, 32'd0);
      key_h[2] = 1'b0;
      step(10);

      // Simultaneous active-low keys
      key_l = 4'h0;
      step(6);
      chk("low_before", {okey_l, opress_l}, 32'h00);
      step(1);
      $display("active-low all: o_key=%b o_press=%b", okey_l, opress_l);
      chk("low_edge", {okey_l, opress_l}, 32'hFF);
      cnt_p  = 0;
      steady = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step(1);
         cnt_p += int'(opress_l != 4'h0) + int'(orel_l != 4'h0);
         if (okey_l != 4'hF) steady = 1'b0;
      end
      chk("low_no_repeat", cnt_p, 32'd0);
      chk("low_steady", 32'(steady), 32'h1);
      key_l = 4'hF;
      step(10);
      chk("low_released", okey_l, 32'h0);

      // Reset mid-count on channel 0 (cnt == 2 after five edges)
      key_h[0] = 1'b1;
      step(5);
      rst = 1'b1;
      step(1);
      chk("midrst_h", {okey_h, opress_h, orel_h}, 32'h0);
      rst = 1'b0;
      step(6);
      chk("midrst_before", {okey_h, opress_h}, 32'h00);
      step(1);
      $display("post-reset press ch0: o_key=%b o_press=%b", okey_h, opress_h);
      chk("midrst_edge", {okey_h, opress_h}, 32'h11);

      // Reset while held: level drops, no release pulse
      step(2);
      rst = 1'b1;
      step(1);
      chk("heldrst", {okey_h, orel_h}, 32'h00);
      rst = 1'b0;
      key_h[0] = 1'b0;
      cnt_r = 0;
      for (int i = 0; i < 10; i++) begin step(1); cnt_r += int'(orel_h[0]) + int'(okey_h[0]); end
      chk("heldrst_quiet", cnt_r, 32'd0);

      // Long hold on channel 3
      key_h[3] = 1'b1;
      cnt_p  = 0;
      steady = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         step(1);
         cnt_p += int'(opress_h[3]);
         if (i >= 6 && !okey_h[3]) steady = 1'b0;
      end
      key_h[3] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         if (!okey_h[3]) steady = 1'b0;
      end
      $display("long hold ch3: presses=%0d steady=%b", cnt_p, steady);
      chk("long_presses", cnt_p, 32'd1);
      chk("long_steady", 32'(steady), 32'h1);
      step(1);
      chk("long_release", {okey_h[3], orel_h[3]}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_debounce_4ch.md
# key_debounce_4ch

Four-channel push-button conditioner that sits directly upstream of the two-digit seven-segment driver and feeds its 4-bit increment input. Each raw mechanical key is synchronised, debounced by a per-channel state machine and stability counter, and presented as a clean level plus one-cycle press and release pulses. The display driver's own edge detector sees exactly one rising edge per physical press.

## Interface
- P_DEBOUNCE, default 'd1_000_000: number of consecutive stable cycles required to accept a level change; legal minimum 2.
- P_CNT_W, default 20: debounce counter width; must satisfy 2^P_CNT_W ≥ P_DEBOUNCE.
- P_KEY_POL, default 1: raw level meaning "pressed". 1 means active-high keys; 0 means active-low keys, which are inverted before synchronisation.
- i_clk  input  1  sole clock; all logic is on its rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_key  input  4  raw asynchronous key levels, one bit per channel.
- o_key  output  4  debounced level, 1 = pressed; connects to the display driver's i_add.
- o_press  output  4  one-cycle pulse per channel on confirmed press.
- o_release  output  4  one-cycle pulse per channel on confirmed release.

## Operation
- **Normalisation:** k = P_KEY_POL ? i_key : ~i_key. After this step, 1 always means pressed.
- **Synchroniser:** each bit passes through a 2-flop chain (s1 → s2). The FSM uses s2 only.
- **Channel independence:** each channel has its own FSM and its own P_CNT_W-bit counter `cnt`. Channels never interact.
- **FSM states per channel:**
  - S_IDLE: stable released.
    - s2=1 → S_PRESS_CHK, cnt←0.
  - S_PRESS_CHK: candidate press.
    - s2=0 → S_IDLE, cnt←0. No pulse is emitted.
    - s2=1 and cnt==P_DEBOUNCE-1 → S_HOLD, o_key←1, o_press←1.
    - s2=1 otherwise → cnt←cnt+1.
  - S_HOLD: stable pressed.
    - s2=0 → S_REL_CHK, cnt←0.
  - S_REL_CHK: candidate release.
    - s2=1 → S_HOLD, cnt←0. No pulse is emitted.
    - s2=0 and cnt==P_DEBOUNCE-1 → S_IDLE, o_key←0, o_release←1.
    - s2=0 otherwise → cnt←cnt+1.
- **Pulse outputs:** o_press and o_release are registered. They are high for exactly one cycle and are 0 in every other cycle.
- **Counter range:** the counter never exceeds P_DEBOUNCE-1, so wrap-around is impossible.
- **Held key:** a key held indefinitely stays in S_HOLD. It produces exactly one o_press and no repeats.
- **Bounce:** any bounce shorter than P_DEBOUNCE cycles is absorbed. The channel returns to its prior stable state with its outputs unchanged.
- **Simultaneous channel events:** any combination of o_press bits may assert in the same cycle.
- **Reset:**
  - s1, s2 ← 0 (released, post-normalisation). This prevents a false press when reset is released.
  - State ← S_IDLE, cnt ← 0.
  - o_key, o_press, o_release ← 4'b0.
- **Reset mid-operation:** reset overrides everything in the same edge. Any in-progress count is abandoned. A key physically held through reset is re-detected as a new press after full latency.

## Timing
- **Definition:** let edge E be the first clock edge at which the new raw level is sampled into s1.
- **Press latency:**
  - s2 holds the new level after E+1.
  - The FSM enters the CHK state at E+2.
  - o_key and o_press update at E+2+P_DEBOUNCE, i.e. they are visible one cycle after the raw change plus P_DEBOUNCE+2 edges.
- **Release latency:** identical to press latency.
- **Stability condition:** the raw level must remain stable for P_DEBOUNCE consecutive s2 samples in the CHK state. One opposite sample restarts from the stable state.
- **Pulse/level alignment:** o_press rises in the same cycle that o_key rises. o_release rises in the same cycle that o_key falls.
- **Minimum spacing:** the shortest accepted press-to-release-to-press period is 2·(P_DEBOUNCE+1) cycles.

## Test plan
- **Clean press/release:** P_DEBOUNCE=4, P_KEY_POL=1. Drive i_key[0]=1 before edge 10 and hold it for 20 cycles, then drive 0.
  - Required: o_key[0] rises and o_press[0] pulses for 1 cycle after edge 16.
  - Required: after the falling edge at E', o_key[0] falls and o_release[0] pulses after E'+6.
- **Bounce rejection:** with P_DEBOUNCE=4, toggle i_key[1] high for 3 cycles, low for 2, high for 3, low.
  - Required: o_key[1], o_press[1] and o_release[1] stay 0 throughout.
- **Bouncy press that finally settles:** apply bursts of 1–3 cycles, then hold high.
  - Required: exactly one o_press[2] pulse, 6 edges after the final rising sample.
- **Simultaneous keys with active-low polarity:** P_KEY_POL=0. Drive i_key from 4'b1111 to 4'b0000 on the same edge and hold.
  - Required: o_key=4'b1111 and o_press=4'b1111 for one cycle, both on the same edge.
  - Required: no further pulses while the keys are held for 100 cycles.
- **Reset mid-count and reset while held:**
  - Assert i_rst for 1 cycle when a channel's cnt is 2 in S_PRESS_CHK with the key still held. Required: all outputs are 0 at the next edge, and o_press fires at the normal latency counted from the first post-reset edge (s2 re-fills).
  - Assert reset while a channel is in S_HOLD. Required: o_key goes to 0 immediately and no o_release pulse is emitted.
- **Long hold:** P_DEBOUNCE=4, hold i_key[3]=1 for 1000 cycles.
  - Required: exactly one o_press[3] pulse.
  - Required: o_key[3] stays 1 continuously until the release latency expires.
